// File: rtl/reg_arb_pkg.sv
// Shared definitions for the reg_f access arbiter.
//   state_t   : two-state arbiter FSM encoding (IDLE / ISSUE)
//   NREQ_MAX  : largest supported requester count
//   calc_aw   : index width helper, never narrower than 1 bit
package reg_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam int NREQ_MAX = 4;

  // Bits needed to index 'count' items; a single item still gets one bit.
  function automatic int calc_aw(input int count);
    if (count > 1) begin
      return $clog2(count);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/reg_f_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports:
//   req     in   NREQ  eligible request mask
//   ptr     in   PW    index with highest priority this round
//   win     out  NREQ  one-hot winner (all zero when nothing requests)
//   win_idx out  PW    binary index of the winner
//   found   out  1     at least one eligible request
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int PW   = calc_aw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   win_idx,
  output logic            found
);

  // One extra bit so ptr + k never overflows before the modulo wrap.
  logic [PW:0] pos_s;

  // Scan ptr, ptr+1, ... (mod NREQ) and keep the first requester seen.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    pos_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos_s = {1'b0, ptr} + (PW+1)'(k);
      if (pos_s >= (PW+1)'(NREQ)) begin
        pos_s = pos_s - (PW+1)'(NREQ);
      end else begin
        pos_s = pos_s;
      end
      if (!found && req[pos_s[PW-1:0]]) begin
        found                = 1'b1;
        win_idx              = pos_s[PW-1:0];
        win[pos_s[PW-1:0]]   = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/reg_f_arb.sv
// reg_f_arb: round-robin arbiter sharing the single reg_f access port among
// NREQ requesters. One access every two cycles (IDLE arbitrates, ISSUE
// executes); reads return data with a one-hot RVALID pulse the cycle after.
// Optional build macro REG_ARB_LOCK_EN adds a LOCK input that lets a winner
// keep exclusive ownership of the port across consecutive accesses.
// Ports:
//   CLK, RSTN          clock, synchronous active-low reset
//   REQ/WE/ADDR/WDATA  per-requester request, direction, index, write data
//   LOCK               (REG_ARB_LOCK_EN only) per-requester lock request
//   GNT, RVALID        one-hot grant and read-valid pulses
//   RDATA              read data, valid while RVALID != 0
//   RF_EN/RF_SEL/RF_IN registered drive to reg_f; RF_OUT from reg_f
module reg_f_arb
  import reg_arb_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int SIZE  = 8,
  parameter  int NREQ  = 2,
  localparam int AW    = calc_aw(SIZE),
  localparam int PW    = calc_aw(NREQ)
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ-1:0]      WE,
  input  logic [NREQ*AW-1:0]   ADDR,
  input  logic [NREQ*WIDTH-1:0] WDATA,
`ifdef REG_ARB_LOCK_EN
  input  logic [NREQ-1:0]      LOCK,
`endif
  output logic [NREQ-1:0]      GNT,
  output logic [NREQ-1:0]      RVALID,
  output logic [WIDTH-1:0]     RDATA,
  output logic                 RF_EN,
  output logic [AW-1:0]        RF_SEL,
  output logic [WIDTH-1:0]     RF_IN,
  input  logic [WIDTH-1:0]     RF_OUT
);

  state_t           state_r;
  logic [PW-1:0]    ptr_r;
  logic [NREQ-1:0]  gnt_r;
  logic [NREQ-1:0]  rvalid_r;
  logic             rf_en_r;
  logic [AW-1:0]    rf_sel_r;
  logic [WIDTH-1:0] rf_in_r;
  logic             rd_pend_r;   // access in ISSUE is a read

  logic [NREQ-1:0]  elig_s;
  logic [NREQ-1:0]  win_s;
  logic [PW-1:0]    win_idx_s;
  logic             found_s;
  logic [PW-1:0]    ptr_nxt_s;
  logic             adv_s;       // rotate the priority pointer on this grant

`ifdef REG_ARB_LOCK_EN
  logic             lock_r;
  logic [PW-1:0]    owner_r;
  logic             lock_act_s;
  logic [NREQ-1:0]  own_mask_s;

  // While the owner still asserts LOCK only its request is eligible and the
  // pointer stays put; a dropped LOCK releases arbitration in the same cycle.
  always_comb begin
    own_mask_s          = '0;
    own_mask_s[owner_r] = 1'b1;
    lock_act_s          = lock_r & LOCK[owner_r];
    if (lock_act_s) begin
      elig_s = REQ & own_mask_s;
    end else begin
      elig_s = REQ;
    end
    adv_s = ~lock_act_s;
  end
`else
  // Pure round-robin: every request is eligible, pointer always advances.
  always_comb begin
    elig_s = REQ;
    adv_s  = 1'b1;
  end
`endif

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req     (elig_s),
    .ptr     (ptr_r),
    .win     (win_s),
    .win_idx (win_idx_s),
    .found   (found_s)
  );

  // Pointer moves to the requester just after the winner, wrapping at NREQ.
  always_comb begin
    if (win_idx_s == PW'(NREQ - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = win_idx_s + PW'(1);
    end
  end

  // Arbiter FSM, reg_f drive registers and read-valid pipeline.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_r   <= IDLE;
      ptr_r     <= '0;
      gnt_r     <= '0;
      rvalid_r  <= '0;
      rf_en_r   <= 1'b0;
      rf_sel_r  <= '0;
      rf_in_r   <= '0;
      rd_pend_r <= 1'b0;
`ifdef REG_ARB_LOCK_EN
      lock_r    <= 1'b0;
      owner_r   <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          rvalid_r <= '0;
          if (found_s) begin
            state_r   <= ISSUE;
            gnt_r     <= win_s;
            rf_en_r   <= WE[win_idx_s];
            rf_sel_r  <= ADDR[int'(win_idx_s)*AW +: AW];
            rf_in_r   <= WDATA[int'(win_idx_s)*WIDTH +: WIDTH];
            rd_pend_r <= ~WE[win_idx_s];
            if (adv_s) begin
              ptr_r <= ptr_nxt_s;
            end else begin
              ptr_r <= ptr_r;
            end
          end else begin
            state_r <= IDLE;
            gnt_r   <= '0;
            rf_en_r <= 1'b0;
          end
`ifdef REG_ARB_LOCK_EN
          if (found_s && LOCK[win_idx_s]) begin
            lock_r  <= 1'b1;
            owner_r <= win_idx_s;
          end else if (lock_r && !LOCK[owner_r]) begin
            lock_r  <= 1'b0;
          end else begin
            lock_r  <= lock_r;
          end
`endif
        end
        ISSUE: begin
          // reg_f performs the access at this edge; report reads next cycle.
          state_r  <= IDLE;
          gnt_r    <= '0;
          rf_en_r  <= 1'b0;
          rvalid_r <= gnt_r & {NREQ{rd_pend_r}};
        end
        default: begin
          state_r  <= IDLE;
          gnt_r    <= '0;
          rf_en_r  <= 1'b0;
          rvalid_r <= '0;
        end
      endcase
    end
  end

  assign GNT    = gnt_r;
  assign RVALID = rvalid_r;
  assign RF_EN  = rf_en_r;
  assign RF_SEL = rf_sel_r;
  assign RF_IN  = rf_in_r;
  // reg_f OUT follows RF_SEL, which is held through the RVALID cycle.
  assign RDATA  = RF_OUT;

endmodule

// File: tb/tb_reg_f_arb.sv
// Directed bench for reg_f_arb with a behavioural reg_f (WIDTH=8, SIZE=8,
// NREQ=2). The lock sequence is included when REG_ARB_LOCK_EN is defined.
module tb_reg_f_arb;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [1:0]  REQ;
  logic [1:0]  WE;
  logic [5:0]  ADDR;
  logic [15:0] WDATA;
`ifdef REG_ARB_LOCK_EN
  logic [1:0]  LOCK;
`endif
  logic [1:0]  GNT;
  logic [1:0]  RVALID;
  logic [7:0]  RDATA;
  logic        RF_EN;
  logic [2:0]  RF_SEL;
  logic [7:0]  RF_IN;
  logic [7:0]  RF_OUT;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural reg_f: write on clock edge when EN, combinational read.
  logic [7:0] mem [8] = '{default: 8'h00};
  always @(posedge CLK) begin
    if (RF_EN) mem[RF_SEL] <= RF_IN;
  end
  assign RF_OUT = mem[RF_SEL];

  always #5 CLK = ~CLK;

  reg_f_arb #(.WIDTH(8), .SIZE(8), .NREQ(2)) dut (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .REQ    (REQ),
    .WE     (WE),
    .ADDR   (ADDR),
    .WDATA  (WDATA),
`ifdef REG_ARB_LOCK_EN
    .LOCK   (LOCK),
`endif
    .GNT    (GNT),
    .RVALID (RVALID),
    .RDATA  (RDATA),
    .RF_EN  (RF_EN),
    .RF_SEL (RF_SEL),
    .RF_IN  (RF_IN),
    .RF_OUT (RF_OUT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One isolated access by requester r, starting in an IDLE cycle.
  task automatic acc(input int r, input logic we, input logic [2:0] a,
                     input logic [7:0] d, input logic [7:0] exp_rd, input string tag);
    logic [1:0] g;
    g = 2'b00;
    g[r] = 1'b1;
    REQ = 2'b00;
    REQ[r] = 1'b1;
    WE[r] = we;
    ADDR[r*3 +: 3] = a;
    WDATA[r*8 +: 8] = d;
    step();
    chk({tag, " gnt"}, GNT, g);
    chk({tag, " rf_en"}, RF_EN, we);
    chk({tag, " rf_sel"}, RF_SEL, a);
    REQ = 2'b00;
    step();
    chk({tag, " gnt_low"}, GNT, 2'b00);
    if (we) begin
      chk({tag, " no_rvalid"}, RVALID, 2'b00);
    end else begin
      chk({tag, " rvalid"}, RVALID, g);
      chk({tag, " rdata"}, RDATA, exp_rd);
    end
  endtask

  initial begin
    RSTN = 1'b0; REQ = 2'b00; WE = 2'b00; ADDR = 6'd0; WDATA = 16'h0000;
`ifdef REG_ARB_LOCK_EN
    LOCK = 2'b00;
`endif
    // 1. Reset
    step(); step();
    chk("rst gnt", GNT, 2'b00);
    chk("rst rvalid", RVALID, 2'b00);
    chk("rst rf_en", RF_EN, 1'b0);
    chk("rst rf_sel", RF_SEL, 3'd0);
    chk("rst rf_in", RF_IN, 8'h00);
    RSTN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle gnt", GNT, 2'b00);
      chk("idle rf_en", RF_EN, 1'b0);
    end

    // 2. Write then read by requester 0
    acc(0, 1'b1, 3'd3, 8'hA5, 8'h00, "t2 wr");
    chk("t2 mem3", mem[3], 8'hA5);
    acc(0, 1'b0, 3'd3, 8'h00, 8'hA5, "t2 rd0");
    acc(1, 1'b0, 3'd3, 8'h00, 8'hA5, "t2 rd1");   // leaves ptr at 0

    // 3. Contention with both requesters held
    REQ = 2'b11; WE = 2'b11; ADDR = {3'd2, 3'd1}; WDATA = {8'h22, 8'h11};
    step(); chk("t3 gnt a", GNT, 2'b01); chk("t3 sel a", RF_SEL, 3'd1);
    step(); chk("t3 gap a", GNT, 2'b00);
    step(); chk("t3 gnt b", GNT, 2'b10); chk("t3 sel b", RF_SEL, 3'd2);
    chk("t3 in b", RF_IN, 8'h22);
    step(); chk("t3 gap b", GNT, 2'b00);
    step(); chk("t3 gnt c", GNT, 2'b01);
    REQ = 2'b00;
    step();
    acc(0, 1'b0, 3'd1, 8'h00, 8'h11, "t3 rb1");
    acc(1, 1'b0, 3'd2, 8'h00, 8'h22, "t3 rb2");

    // 4. Read then write of the same register
    acc(0, 1'b1, 3'd5, 8'h3C, 8'h00, "t4 pre");
    REQ = 2'b10; WE = 2'b00; ADDR = {3'd5, 3'd0};
    step(); chk("t4 gnt rd", GNT, 2'b10);
    REQ = 2'b01; WE = 2'b01; ADDR = {3'd0, 3'd5}; WDATA = {8'h00, 8'h5C};
    step();
    chk("t4 rvalid", RVALID, 2'b10);
    chk("t4 old data", RDATA, 8'h3C);
    chk("t4 gap", GNT, 2'b00);
    step();
    chk("t4 gnt wr", GNT, 2'b01);
    chk("t4 rf_en", RF_EN, 1'b1);
    REQ = 2'b00;
    step(); chk("t4 wr no_rvalid", RVALID, 2'b00);
    acc(1, 1'b0, 3'd5, 8'h00, 8'h5C, "t4 rd new");

    // 5. Reset during ISSUE of a read by requester 0 (ptr moved to 1)
    REQ = 2'b01; WE = 2'b00; ADDR = {3'd0, 3'd5};
    step(); chk("t5 gnt", GNT, 2'b01);
    RSTN = 1'b0; REQ = 2'b00;
    step();
    chk("t5 rvalid", RVALID, 2'b00);
    chk("t5 gnt", GNT, 2'b00);
    chk("t5 rf_sel", RF_SEL, 3'd0);
    RSTN = 1'b1; REQ = 2'b11; WE = 2'b00; ADDR = {3'd2, 3'd1};
    step(); chk("t5 first gnt", GNT, 2'b01);
    REQ = 2'b00;
    step();
    chk("t5 rvalid0", RVALID, 2'b01);
    chk("t5 rdata", RDATA, 8'h11);

`ifdef REG_ARB_LOCK_EN
    // 6. Lock held by requester 0 for three accesses
    acc(1, 1'b0, 3'd2, 8'h00, 8'h22, "t6 pre");   // ptr back to 0
    REQ = 2'b11; WE = 2'b00; ADDR = {3'd2, 3'd1}; LOCK = 2'b01;
    step(); chk("t6 gnt 1", GNT, 2'b01);
    step();
    step(); chk("t6 gnt 2", GNT, 2'b01);
    step();
    step(); chk("t6 gnt 3", GNT, 2'b01);
    LOCK = 2'b00;
    step(); chk("t6 gap", GNT, 2'b00);
    step(); chk("t6 unlocked", GNT, 2'b10);
    REQ = 2'b00;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
